// File: rtl/spi_flash_pkg.sv
// Shared opcodes and state encoding for the SPI-flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        STAT,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the byte-wide memory fetch port of the flash responder.
// slave is the responder side; master is the initiator/memory side.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_sclk;
    logic              chip_select;
    logic              spi_si;
    logic              spi_so;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport slave (
        input  spi_sclk, chip_select, spi_si, mem_ack, mem_data,
        output spi_so, mem_addr, mem_req
    );

    modport master (
        output spi_sclk, chip_select, spi_si, mem_ack, mem_data,
        input  spi_so, mem_addr, mem_req
    );
endinterface

// File: rtl/spi_flash_responder_pin_sync.sv
// Three-flop pin synchroniser: two flops for metastability, the third
// gives the previous synchronised value for edge detection.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    // Shift the pin through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash target answering READ, RDID and RDSR from a
// byte-wide memory with a one-byte prefetch buffer.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W     = 24,
    parameter logic [23:0] JEDEC_ID   = 24'h010216,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_flash_responder_if.slave bus,
    output logic                 underrun,
    output logic                 busy
);
    logic              sclk_lvl_unused, sclk_rise, sclk_fall;
    logic              cs_lvl, cs_rise, cs_fall;
    logic              si_s1, si_s2;
    state_t            state;
    logic [4:0]        bit_cnt;
    logic [22:0]       in_sr;
    logic [23:0]       out_sr;
    logic [ADDR_W-1:0] addr, addr_nxt, fetch_addr, maddr_q;
    logic [7:0]        buf_q, load_byte, cmd_byte;
    logic [23:0]       addr_word;
    logic              buf_valid, drop_ack, fetch_pend, so_q, req_q;
    logic              req_busy, fetch_evt, load_ok;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .pin(bus.spi_sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs resets to the deselected level so reset release is not seen as a fall.
    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .pin(bus.chip_select),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    // Data-in pin only needs the two-flop path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            si_s1 <= 1'b0;
            si_s2 <= 1'b0;
        end else begin
            si_s1 <= bus.spi_si;
            si_s2 <= si_s1;
        end
    end

    assign cmd_byte  = {in_sr[6:0], si_s2};
    assign addr_word = {in_sr, si_s2};
    assign addr_nxt  = addr + 1'b1;
    assign req_busy  = req_q & ~bus.mem_ack;

    // Fetch trigger and byte source; an ack landing on the load fall bypasses the buffer.
    always_comb begin
        fetch_evt  = 1'b0;
        fetch_addr = addr_nxt;
        load_byte  = 8'hFF;
        load_ok    = 1'b0;
        if (!cs_lvl) begin
            if (state == ADDR && sclk_rise && bit_cnt == 5'd23) begin
                fetch_evt  = 1'b1;
                fetch_addr = addr_word[ADDR_W-1:0];
            end else if (state == DATA && sclk_fall && bit_cnt == 5'd0) begin
                fetch_evt = 1'b1;
            end
        end
        if (req_q && bus.mem_ack && !drop_ack) begin
            load_byte = bus.mem_data;
            load_ok   = 1'b1;
        end else if (buf_valid) begin
            load_byte = buf_q;
            load_ok   = 1'b1;
        end
    end

    // Command FSM, shifters, prefetch buffer and memory request handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            in_sr      <= '0;
            out_sr     <= '0;
            addr       <= '0;
            buf_q      <= '0;
            buf_valid  <= 1'b0;
            drop_ack   <= 1'b0;
            fetch_pend <= 1'b0;
            so_q       <= 1'b0;
            req_q      <= 1'b0;
            maddr_q    <= '0;
            underrun   <= 1'b0;
        end else begin
            if (req_q && bus.mem_ack) begin
                req_q    <= 1'b0;
                drop_ack <= 1'b0;
                if (!drop_ack) begin
                    buf_q     <= bus.mem_data;
                    buf_valid <= 1'b1;
                end
            end

            if (cs_lvl) begin
                state      <= IDLE;
                so_q       <= 1'b0;
                bit_cnt    <= '0;
                buf_valid  <= 1'b0;
                fetch_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            in_sr   <= {in_sr[21:0], si_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (cmd_byte)
                                    CMD_READ: state <= ADDR;
                                    CMD_RDID: begin
                                        state  <= ID;
                                        out_sr <= JEDEC_ID;
                                    end
                                    CMD_RDSR: begin
                                        state  <= STAT;
                                        out_sr <= {STATUS_VAL, 16'h0000};
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            in_sr   <= {in_sr[21:0], si_s2};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                addr    <= fetch_addr;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_fall) begin
                            if (bit_cnt == 5'd0) begin
                                so_q          <= load_byte[7];
                                out_sr[23:16] <= {load_byte[6:0], 1'b0};
                                buf_valid     <= 1'b0;
                                addr          <= fetch_addr;
                                if (!load_ok) underrun <= 1'b1;
                            end else begin
                                so_q   <= out_sr[23];
                                out_sr <= {out_sr[22:0], 1'b0};
                            end
                            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                        end
                    end
                    ID: begin
                        if (sclk_fall) begin
                            if (bit_cnt != 5'd24) begin
                                so_q    <= out_sr[23];
                                out_sr  <= {out_sr[22:0], 1'b0};
                                bit_cnt <= bit_cnt + 5'd1;
                            end else begin
                                so_q <= 1'b0;
                            end
                        end
                    end
                    STAT: begin
                        if (sclk_fall) begin
                            so_q          <= out_sr[23];
                            out_sr[23:16] <= {out_sr[22:16], out_sr[23]};
                        end
                    end
                    IGNORE: so_q <= 1'b0;
                    default: state <= IDLE;
                endcase
            end

            // A fetch wanted while one is in flight retires the old one unused.
            if (cs_rise && req_busy) begin
                drop_ack <= 1'b1;
            end
            if (fetch_evt) begin
                if (req_busy) begin
                    drop_ack   <= 1'b1;
                    fetch_pend <= 1'b1;
                end else begin
                    req_q      <= 1'b1;
                    maddr_q    <= fetch_addr;
                    fetch_pend <= 1'b0;
                end
            end else if (fetch_pend && !cs_lvl && !req_busy) begin
                req_q      <= 1'b1;
                maddr_q    <= addr;
                fetch_pend <= 1'b0;
            end
        end
    end

    assign bus.spi_so   = so_q;
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = maddr_q;
    assign busy         = ~cs_lvl;
endmodule
